// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared single-port data/instruction memory.
// The CPU control FSM and an external host port compete for the memory. Each
// granted access walks IDLE -> ACCESS -> RESP, and ties alternate round-robin.
// The memory macro reads synchronously with one cycle of latency, so read data
// lands in RESP. It is forwarded combinationally there and captured for later.
module mem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_ack,
  output logic              ext_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  access_count
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_EXT = 1'b1} owner_t;

  state_t             r_state, w_next;
  owner_t             r_owner;      // current owner; doubles as last owner for round-robin
  logic               r_we;         // direction of the access in flight
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_mem_re, r_mem_we;
  logic [DATA_W-1:0]  r_cpu_rdata, r_ext_rdata;
  logic [CNT_W-1:0]   r_count;

  logic w_start;     // leaving IDLE this edge
  logic w_pick_ext;  // arbitration result, meaningful only with w_start
  logic w_in_resp;

  // Arbitration: a lone requester wins; on a tie the port not served last wins.
  always_comb begin
    w_start    = (r_state == S_IDLE) && (cpu_req || ext_req);
    w_pick_ext = ext_req && (!cpu_req || (r_owner == OWN_CPU));
    w_in_resp  = (r_state == S_RESP);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next state and handshake outputs. No bypass of IDLE between accesses.
  always_comb begin
    w_next  = r_state;
    cpu_ack = 1'b0;
    ext_ack = 1'b0;
    busy    = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:   if (cpu_req || ext_req) w_next = S_ACCESS;
      S_ACCESS: w_next = S_RESP;
      S_RESP: begin
        w_next  = S_IDLE;
        cpu_ack = (r_owner == OWN_CPU);
        ext_ack = (r_owner == OWN_EXT);
      end
      default:  w_next = S_IDLE;
    endcase
  end

  // Grant capture: owner, direction and memory address/data load from the winner.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner     <= OWN_EXT;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_start) begin
      r_owner     <= w_pick_ext ? OWN_EXT : OWN_CPU;
      r_we        <= w_pick_ext ? ext_we : cpu_we;
      r_mem_addr  <= w_pick_ext ? ext_addr : cpu_addr;
      r_mem_wdata <= w_pick_ext ? ext_wdata : cpu_wdata;
    end
  end

  // Memory strobes: high for the ACCESS cycle only; reset kills an in-flight write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
    end else if (w_start) begin
      r_mem_re <= w_pick_ext ? !ext_we : !cpu_we;
      r_mem_we <= w_pick_ext ? ext_we : cpu_we;
    end else if (r_state == S_ACCESS) begin
      r_mem_re <= 1'b0;
      r_mem_we <= 1'b0;
    end
  end

  // Per-port read data holding registers, updated only by that port's reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= '0;
      r_ext_rdata <= '0;
    end else if (w_in_resp && !r_we) begin
      if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
      else                    r_ext_rdata <= mem_rdata;
    end
  end

  // Completed-access counter, wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_count <= '0;
    else if (w_in_resp) r_count <= r_count + 1'b1;
  end

  // Read data is forwarded in the ack cycle so the requester sees it without delay.
  always_comb begin
    cpu_rdata = (cpu_ack && !r_we) ? mem_rdata : r_cpu_rdata;
    ext_rdata = (ext_ack && !r_we) ? mem_rdata : r_ext_rdata;
    cpu_stall = cpu_req && !cpu_ack;
    ext_stall = ext_req && !ext_ack;
  end

  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_re       = r_mem_re;
  assign mem_we       = r_mem_we;
  assign access_count = r_count;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a behavioural memory macro, and a
// transaction-level model that predicts ack cycles, strobes, read data and counts.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, cpu_stall, ext_ack, ext_stall, mem_re, mem_we, busy;
  logic [15:0] access_count;
  // narrow-counter instance for the wrap check
  logic [7:0] n_cpu_rdata, n_ext_rdata, n_mem_addr, n_mem_wdata;
  logic       n_cpu_ack, n_cpu_stall, n_ext_ack, n_ext_stall, n_mem_re, n_mem_we, n_busy;
  logic [3:0] n_count;

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  logic       pl_en;

  int errors = 0;
  int checks = 0;
  bit m_last_ext;          // model: port served most recently (1 = EXT)
  int exp_count;
  logic [7:0] exp_crd, exp_erd;

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack), .ext_stall(ext_stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .access_count(access_count));

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(n_cpu_rdata), .cpu_ack(n_cpu_ack), .cpu_stall(n_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(n_ext_rdata), .ext_ack(n_ext_ack), .ext_stall(n_ext_stall),
    .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata), .mem_re(n_mem_re), .mem_we(n_mem_we),
    .mem_rdata(mem_rdata), .busy(n_busy), .access_count(n_count));

  // Memory macro: synchronous read, one-cycle latency; preload copies ref_mem.
  always @(posedge clock) begin
    if (pl_en) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic model_reset();
    m_last_ext = 1'b1;
    exp_count  = 0;
    exp_crd    = 8'h00;
    exp_erd    = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  // One transaction set: each enabled port raises req at cycle 0, holds it
  // until its own ack, then drops it. The model derives timing from the rules:
  // first grant acks at cycle 2, the second at cycle 5.
  task automatic run_trial(input bit c_on, input bit e_on, input bit c_w, input bit e_w,
                           input logic [7:0] c_a, input logic [7:0] e_a,
                           input logic [7:0] c_d, input logic [7:0] e_d);
    int c_ack = -1;
    int e_ack = -1;
    int last;
    bit win_ext;
    if (c_on && e_on) begin
      win_ext = !m_last_ext;
      if (win_ext) begin e_ack = 2; c_ack = 5; end
      else begin c_ack = 2; e_ack = 5; end
      m_last_ext = !win_ext;
    end else if (c_on) begin
      c_ack = 2; m_last_ext = 1'b0;
    end else begin
      e_ack = 2; m_last_ext = 1'b1;
    end
    last = (c_ack > e_ack) ? c_ack : e_ack;
    cpu_req = c_on; cpu_we = c_w; cpu_addr = c_a; cpu_wdata = c_d;
    ext_req = e_on; ext_we = e_w; ext_addr = e_a; ext_wdata = e_d;
    for (int c = 0; c <= last; c++) begin
      #1;
      if (c == c_ack && !c_w) exp_crd = ref_mem[c_a];
      if (c == e_ack && !e_w) exp_erd = ref_mem[e_a];
      checks++;
      if (cpu_ack !== (c == c_ack) || ext_ack !== (c == e_ack)) begin
        errors++;
        $display("FAIL trial_ack c=%0d: cpu_ack=%b ext_ack=%b want %b %b", c, cpu_ack, ext_ack, c == c_ack, c == e_ack);
      end
      checks++;
      if (cpu_stall !== (cpu_req && c != c_ack) || ext_stall !== (ext_req && c != e_ack)) begin
        errors++;
        $display("FAIL trial_stall c=%0d: cpu=%b ext=%b", c, cpu_stall, ext_stall);
      end
      checks++;
      if (cpu_rdata !== exp_crd || ext_rdata !== exp_erd) begin
        errors++;
        $display("FAIL trial_rdata c=%0d: cpu=%h ext=%h want %h %h", c, cpu_rdata, ext_rdata, exp_crd, exp_erd);
      end
      checks++;
      if (busy !== (c % 3 != 0)) begin
        errors++;
        $display("FAIL trial_busy c=%0d: got %b want %b", c, busy, c % 3 != 0);
      end
      checks++;
      if (access_count !== exp_count[15:0] || n_count !== exp_count[3:0]) begin
        errors++;
        $display("FAIL trial_count c=%0d: got %0d/%0d want %0d/%0d", c, access_count, n_count, exp_count[15:0], exp_count[3:0]);
      end
      if (c == c_ack - 1) begin
        checks++;
        if (mem_re !== !c_w || mem_we !== c_w || mem_addr !== c_a || (c_w && mem_wdata !== c_d)) begin
          errors++;
          $display("FAIL trial_cpu_strobe: re=%b we=%b a=%h d=%h want we=%b a=%h d=%h", mem_re, mem_we, mem_addr, mem_wdata, c_w, c_a, c_d);
        end
      end
      if (c == e_ack - 1) begin
        checks++;
        if (mem_re !== !e_w || mem_we !== e_w || mem_addr !== e_a || (e_w && mem_wdata !== e_d)) begin
          errors++;
          $display("FAIL trial_ext_strobe: re=%b we=%b a=%h d=%h want we=%b a=%h d=%h", mem_re, mem_we, mem_addr, mem_wdata, e_w, e_a, e_d);
        end
      end
      if (c == c_ack) begin
        if (c_w) ref_mem[c_a] = c_d;
        exp_count++;
        cpu_req = 0;
      end
      if (c == e_ack) begin
        if (e_w) ref_mem[e_a] = e_d;
        exp_count++;
        ext_req = 0;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 11);
    ref_mem[8'h10] = 8'hA5;
    pl_en = 1'b1;
    reset = 1'b1;
    tick(); tick();
    pl_en = 1'b0;
    checks++;
    if (cpu_ack !== 0 || ext_ack !== 0 || mem_re !== 0 || mem_we !== 0 || busy !== 0 ||
        access_count !== 0 || cpu_rdata !== 0 || ext_rdata !== 0 || mem_addr !== 0 || mem_wdata !== 0) begin
      errors++;
      $display("FAIL reset_values: ack=%b%b re=%b we=%b busy=%b cnt=%0d rd=%h/%h a=%h d=%h",
               cpu_ack, ext_ack, mem_re, mem_we, busy, access_count, cpu_rdata, ext_rdata, mem_addr, mem_wdata);
    end
    cpu_req = 1; #1;
    checks++;
    if (cpu_stall !== 1 || ext_stall !== 0) begin
      errors++;
      $display("FAIL reset_stall: cpu=%b ext=%b want 1 0", cpu_stall, ext_stall);
    end
    cpu_req = 0;
    reset = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_cpu_read();
    run_trial(1, 0, 0, 0, 8'h10, 8'h00, 8'h00, 8'h00);
    checks++;
    if (cpu_rdata !== 8'hA5 || access_count !== 16'd1) begin
      errors++;
      $display("FAIL cpu_read_after: rdata=%h cnt=%0d want a5 1", cpu_rdata, access_count);
    end
  endtask

  // Both ports hold their requests; grants must go CPU, EXT, CPU.
  task automatic test_tie_held();
    logic [7:0] ca, ea;
    do_reset();
    ca = 8'(($urandom % 64) + 64);
    ea = 8'(($urandom % 64) + 128);
    cpu_req = 1; cpu_addr = ca; ext_req = 1; ext_addr = ea;
    for (int c = 0; c <= 8; c++) begin
      #1;
      if (c == 2 || c == 8) exp_crd = ref_mem[ca];
      if (c == 5) exp_erd = ref_mem[ea];
      checks++;
      if (cpu_ack !== (c == 2 || c == 8) || ext_ack !== (c == 5) ||
          cpu_stall !== !(c == 2 || c == 8) || ext_stall !== (c != 5)) begin
        errors++;
        $display("FAIL tie_held c=%0d: ack=%b%b stall=%b%b", c, cpu_ack, ext_ack, cpu_stall, ext_stall);
      end
      checks++;
      if (cpu_rdata !== exp_crd || ext_rdata !== exp_erd) begin
        errors++;
        $display("FAIL tie_rdata c=%0d: cpu=%h ext=%h want %h %h", c, cpu_rdata, ext_rdata, exp_crd, exp_erd);
      end
      if (c == 2 || c == 5 || c == 8) exp_count++;
      if (c == 8) begin cpu_req = 0; ext_req = 0; end
      tick();
    end
    m_last_ext = 1'b0;
    checks++;
    if (busy !== 0 || access_count !== 16'd3) begin
      errors++;
      $display("FAIL tie_end: busy=%b cnt=%0d want 0 3", busy, access_count);
    end
  endtask

  task automatic test_write_read();
    run_trial(0, 1, 0, 1, 8'h00, 8'h20, 8'h00, 8'h3C);
    run_trial(1, 0, 0, 0, 8'h20, 8'h00, 8'h00, 8'h00);
    checks++;
    if (cpu_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL write_read: cpu_rdata=%h want 3c", cpu_rdata);
    end
  endtask

  task automatic test_drop_after_grant();
    logic [7:0] want;
    want = ref_mem[8'h10];
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1; tick();
    cpu_req = 0; #1;
    checks++;
    if (cpu_stall !== 0 || busy !== 1 || mem_re !== 1) begin
      errors++;
      $display("FAIL drop_c1: stall=%b busy=%b re=%b want 0 1 1", cpu_stall, busy, mem_re);
    end
    tick();
    checks++;
    if (cpu_ack !== 1 || cpu_rdata !== want) begin
      errors++;
      $display("FAIL drop_ack: ack=%b rdata=%h want 1 %h", cpu_ack, cpu_rdata, want);
    end
    exp_count++; exp_crd = want; m_last_ext = 1'b0;
    tick();
    for (int c = 3; c <= 4; c++) begin
      checks++;
      if (busy !== 0 || cpu_ack !== 0) begin
        errors++;
        $display("FAIL drop_idle c=%0d: busy=%b ack=%b want 0 0", c, busy, cpu_ack);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] old;
    old = ref_mem[8'h30];
    ext_req = 1; ext_we = 1; ext_addr = 8'h30; ext_wdata = ~old;
    #1; tick();
    checks++;
    if (mem_we !== 1) begin
      errors++;
      $display("FAIL rst_mid_pre: mem_we=%b want 1", mem_we);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 0 || mem_re !== 0 || busy !== 0 || ext_ack !== 0 || access_count !== 0) begin
      errors++;
      $display("FAIL rst_mid_async: we=%b re=%b busy=%b ack=%b cnt=%0d", mem_we, mem_re, busy, ext_ack, access_count);
    end
    ext_req = 0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (ext_ack !== 0 || access_count !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL rst_mid_after c=%0d: ack=%b cnt=%0d busy=%b", c, ext_ack, access_count, busy);
      end
    end
    checks++;
    if (mem[8'h30] !== old) begin
      errors++;
      $display("FAIL rst_mid_mem: mem[30]=%h want %h", mem[8'h30], old);
    end
    // first tie after reset must go to the CPU
    run_trial(1, 1, 0, 0, 8'h31, 8'h32, 8'h00, 8'h00);
  endtask

  task automatic test_count_wrap();
    // 2 accesses already done since reset; 15 more gives 17
    for (int t = 0; t < 15; t++) begin
      run_trial(t[0], !t[0], $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
    checks++;
    if (n_count !== 4'd1 || access_count !== 16'd17) begin
      errors++;
      $display("FAIL count_wrap: narrow=%0d wide=%0d want 1 17", n_count, access_count);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int k;
      k = $urandom_range(0, 2);
      run_trial(k != 1, k != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    pl_en = 1'b0;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_cpu_read();
    test_tie_held();
    test_write_read();
    test_drop_after_grant();
    test_reset_mid_access();
    test_count_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the processor's single-port data/instruction memory between two requesters: the multicycle control FSM's memory path (fetch, load, store) and an external host port (program loader / debug). Each granted access runs through a fixed three-state sequence (select, access, respond). The block stalls the losing requester with a handshake and alternates grants round-robin under contention. It sits between the datapath memory-address/data muxes and the memory macro, which has synchronous read with one-cycle latency.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data width
- CNT_W, 16, width of completed-access counter

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cpu_req  in  1  CPU access request; held with stable cpu_we/addr/wdata until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack; FSM holds its state while high
- ext_req, ext_we, ext_addr, ext_wdata  in  1/1/ADDR_W/DATA_W  same rules as cpu_*
- ext_rdata  out  DATA_W; ext_ack  out  1  same rules as cpu_*
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re
- busy  out  1  state != IDLE
- access_count  out  CNT_W  completed accesses, both ports, wraps

## Operation
- States: IDLE, ACCESS, RESP. IDLE -> ACCESS when either req is high at the edge. ACCESS -> RESP unconditionally. RESP -> IDLE unconditionally. No back-to-back bypass of IDLE.
- Arbitration, at the IDLE exit edge only:
  - Single requester wins.
  - Both requesting: the port not granted last wins. last_owner resets to EXT, so the CPU wins the first tie.
  - owner and last_owner update on that edge.
- On the IDLE exit edge, mem_addr/mem_wdata load from the winner, and mem_re/mem_we load from the winner's we (~we / we). Both strobes clear on the ACCESS exit edge.
- RESP:
  - owner's ack = 1.
  - Owner's rdata = mem_rdata combinationally for reads.
  - Owner's rdata holding register loads mem_rdata at the RESP exit edge on reads and holds until the next completed read on that port.
  - On writes, rdata holds its previous value.
- The non-owner's ack stays 0; its stall stays high while its req is high.
- A request dropped after grant does not abort: the access completes and ack still pulses.
- A request dropped before grant is never served.
- req still high in the cycle after ack is sampled as a new request in IDLE.
- access_count increments by 1 at every RESP exit edge, wrapping modulo 2^CNT_W.
- Reset (asynchronous, any state):
  - State -> IDLE; mem_re = mem_we = 0 immediately, so an in-flight write is suppressed.
  - acks = 0, rdata registers = 0, mem_addr = mem_wdata = 0, access_count = 0, last_owner = EXT.
  - No ack is issued for an interrupted access.

## Timing
- Request first high at edge N with the arbiter in IDLE:
  - mem_re/mem_we high in cycle N+1.
  - ack high in cycle N+2, with read data valid in that cycle.
  - Arbiter back in IDLE at cycle N+3.
- Throughput: one access per 3 cycles. The loser of a tie is served with ack at N+5.
- Request arriving while busy waits for IDLE; latency = remaining busy cycles + 2.
- Reset values: every output 0, except cpu_stall/ext_stall, which follow req combinationally.

## Test plan
- CPU read: mem[0x10] = 0xA5, cpu_req/addr 0x10 at edge 0.
  - Cycle 1: mem_re = 1, mem_addr = 0x10.
  - Cycle 2: cpu_ack = 1, cpu_rdata = 0xA5, cpu_stall = 0.
  - cpu_rdata stays 0xA5 afterward; access_count = 1.
- Tie after reset: cpu and ext both request at edge 0.
  - CPU acks in cycle 2.
  - ext_ack in cycle 5 with ext_stall high in cycles 0-4.
  - Held requests then alternate CPU, EXT, CPU.
- Write then read: ext writes 0x3C to 0x20.
  - mem_we = 1 in cycle 1, ext_rdata unchanged.
  - cpu then reads 0x20 and gets cpu_rdata = 0x3C.
- Drop after grant: cpu_req high only in cycle 0.
  - Access still completes with cpu_ack in cycle 2.
  - No second access; busy = 0 in cycle 3.
- Reset mid-access: ext write in ACCESS, reset asserted mid-cycle 1.
  - mem_we falls immediately; ext_ack never pulses.
  - Memory unchanged, access_count = 0, first post-reset tie goes to CPU.
- Counter wrap: CNT_W = 4, 17 completed accesses -> access_count = 1.
